pmod_da2_tx: RTL

Serial transmitter for the PmodDA2 (DAC121S101-class) audio output path. It accepts one 12-bit sample per valid/ready handshake and shifts a 16-bit frame MSB-first on dac_din. The frame is framed by active-low dac_sync_n and clocked by a divided dac_sclk. It is the playback-side counterpart of the microphone capture controller, and is fed by the audio datapath at the sample rate.

---
 rtl/pmod_da2_pkg.sv | 30 +++
 rtl/pmod_da2_tx_if.sv | 31 +++
 rtl/clk_div_tick.sv | 35 +++
 rtl/pmod_da2_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pmod_da2_pkg.sv
// Shared definitions for the PmodDA2 serial transmitter.
// Contents:
//   state_t      transmitter FSM states
//   FRAME_W      DAC serial frame width in bits
//   PD_*         DAC power-down codes, carried in frame bits [13:12]
//   build_frame  assembles {2'b00, pd, code} for the DAC121S101
package pmod_da2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    QUIET
  } state_t;

  localparam int FRAME_W = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // The two top bits of a DAC121S101 frame are don't-care; they are driven
  // as zero so that captured frames are deterministic.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]  pd,
                                                     input logic [11:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/pmod_da2_tx_if.sv
// Sample handshake between the audio datapath and the PmodDA2 transmitter.
// Signals:
//   sample_valid  source has a sample on sample_data/pd_mode
//   sample_ready  transmitter can accept a sample this cycle
//   sample_data   unsigned DAC code, DATA_W bits
//   pd_mode       DAC power-down bits
// Modports: master = sample source, slave = transmitter.
interface pmod_da2_tx_if #(
  parameter int DATA_W = 12
);

  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_data;
  logic [1:0]        pd_mode;

  modport master (
    output sample_valid,
    output sample_data,
    output pd_mode,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  pd_mode,
    output sample_ready
  );

endinterface

// File: rtl/clk_div_tick.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous restart; the cycle after clr is count 0
//   tick   high while the count sits at CLK_DIV-1
// With CLK_DIV=1 the tick is permanently high.
module clk_div_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  // Count 0..CLK_DIV-1 and wrap; a clear restarts the half-period so that
  // every new state gets a full CLK_DIV cycles before its first tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/pmod_da2_tx.sv
// PmodDA2 (DAC121S101) serial transmitter.
// Accepts one sample per valid/ready handshake and sends the 16-bit frame
// {2'b00, pd_mode, sample_data} MSB first on dac_din, framed by dac_sync_n
// and clocked by dac_sclk = clk/(2*CLK_DIV).
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   dac_en       allows new samples to be accepted
//   sample       handshake interface (slave side)
//   busy         high from accept until the done cycle
//   done         one-cycle pulse at frame completion
//   dac_sync_n   DAC frame select, active low
//   dac_sclk     DAC serial clock, idles high
//   dac_din      DAC serial data
module pmod_da2_tx
  import pmod_da2_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DATA_W   = 12,
  parameter int QUIET_HP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dac_en,
  pmod_da2_tx_if.slave        sample,
  output logic                busy,
  output logic                done,
  output logic                dac_sync_n,
  output logic                dac_sclk,
  output logic                dac_din
);

  // The last cycle of the quiet gap is spent back in IDLE with done high,
  // so the next accept can land on the done cycle while dac_sync_n has
  // still been high for the full QUIET_HP half-periods.
  localparam int QUIET_CYC = QUIET_HP * CLK_DIV;
  localparam bit HAS_QUIET = (QUIET_CYC > 1);
  localparam int QW        = $clog2(QUIET_CYC + 1);
  localparam int BW        = $clog2(FRAME_W);
  localparam logic [QW-1:0] Q_LAST = HAS_QUIET ? QW'(QUIET_CYC - 2) : '0;

  state_t              state, state_nxt;
  logic [FRAME_W-1:0]  shreg, shreg_nxt;
  logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [QW-1:0]       q_cnt, q_cnt_nxt;
  logic                sync_nxt, sclk_nxt, din_nxt, busy_nxt, done_nxt;
  logic                accept, tick, div_clr;
  logic [DATA_W-1:0]   code;
  logic [FRAME_W-1:0]  frame;

  assign sample.sample_ready = rst_n && dac_en && (state == IDLE);
  assign accept              = sample.sample_valid && sample.sample_ready;
  assign code                = sample.sample_data;
  assign frame               = build_frame(sample.pd_mode, code);
  assign div_clr             = accept || (state_nxt != state);

  clk_div_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  // State and every output pin are registered together so that no input
  // reaches the DAC pins combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      q_cnt      <= '0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      q_cnt      <= q_cnt_nxt;
      dac_sync_n <= sync_nxt;
      dac_sclk   <= sclk_nxt;
      dac_din    <= din_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and next-output logic. In SHIFT each tick toggles dac_sclk;
  // the falling edge is where the DAC samples, so data only moves on the
  // rising toggle, keeping dac_din stable across every falling edge.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    q_cnt_nxt   = q_cnt;
    sync_nxt    = dac_sync_n;
    sclk_nxt    = dac_sclk;
    din_nxt     = dac_din;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        sync_nxt = 1'b1;
        sclk_nxt = 1'b1;
        din_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (accept) begin
          shreg_nxt = frame;
          din_nxt   = frame[FRAME_W-1];
          sync_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = LEAD;
        end
      end

      LEAD: begin
        if (tick) begin
          bit_cnt_nxt = BW'(FRAME_W - 1);
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (dac_sclk) begin
            sclk_nxt = 1'b0;
          end else if (bit_cnt == '0) begin
            sclk_nxt  = 1'b1;
            sync_nxt  = 1'b1;
            din_nxt   = 1'b0;
            q_cnt_nxt = '0;
            if (HAS_QUIET) begin
              state_nxt = QUIET;
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            sclk_nxt    = 1'b1;
            shreg_nxt   = {shreg[FRAME_W-2:0], 1'b0};
            din_nxt     = shreg[FRAME_W-2];
            bit_cnt_nxt = bit_cnt - 1'b1;
          end
        end
      end

      QUIET: begin
        if (q_cnt == Q_LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          q_cnt_nxt = q_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
